// File: rtl/spi_ram_wrapper.sv
// rtl/spi_ram_wrapper.sv - SPI slave front end feeding a single-port RAM with serial read-back

// Serial frame receiver/transmitter: collects 11-bit frames into the rx bus, shifts tx bytes out on MISO
module spi_slave #(
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SS_n,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [FRAME_WIDTH+1:0] rx_data,
  output logic                   rx_valid,
  input  logic [FRAME_WIDTH-1:0] tx_data,
  input  logic                   tx_valid
);
  localparam int RXW = FRAME_WIDTH + 2;
  localparam int CW  = $clog2(RXW + 1);
  localparam int TCW = $clog2(FRAME_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK_CMD = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    READ_TX = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [RXW-2:0]         shreg;
  logic [RXW-1:0]         frame_nxt;
  logic                   shifting;
  logic                   last_bit;
  logic [FRAME_WIDTH-1:0] tx_shift;
  logic [TCW-1:0]         tx_cnt;
  logic                   tx_active;

  // The frame as it will look once this edge's MOSI bit is shifted in
  assign frame_nxt = {shreg, MOSI};
  // Bits are only taken in WRITE/READ until all ten post-c2 bits have arrived; later MOSI is ignored
  assign shifting  = (state == WRITE || state == READ) && (cnt < CW'(RXW));
  assign last_bit  = shifting && (cnt == CW'(RXW - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: deselect always wins; c2 picks the path; a read-data request diverts to READ_TX
  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: state_nxt = MOSI ? READ : WRITE;
        READ:    if (last_bit && frame_nxt[RXW-1:RXW-2] == 2'b11) state_nxt = READ_TX;
        default: state_nxt = state;
      endcase
    end
  end

  // Receive shifter, one-cycle rx_valid pulse, and MSB-first MISO serializer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        cnt       <= '0;
        tx_cnt    <= '0;
        tx_active <= 1'b0;
        MISO      <= 1'b0;
      end else begin
        if (state == IDLE) cnt <= '0;
        if (shifting) begin
          shreg <= frame_nxt[RXW-2:0];
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            rx_valid <= 1'b1;
            rx_data  <= frame_nxt;
          end
        end
        if (state == READ_TX) begin
          if (tx_valid) begin
            MISO      <= tx_data[FRAME_WIDTH-1];
            tx_shift  <= {tx_data[FRAME_WIDTH-2:0], 1'b0};
            tx_cnt    <= TCW'(FRAME_WIDTH - 1);
            tx_active <= 1'b1;
          end else if (tx_active) begin
            if (tx_cnt != '0) begin
              MISO     <= tx_shift[FRAME_WIDTH-1];
              tx_shift <= {tx_shift[FRAME_WIDTH-2:0], 1'b0};
              tx_cnt   <= tx_cnt - 1'b1;
            end else begin
              MISO      <= 1'b0;
              tx_active <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// Command decoder plus storage: address registers, write port and registered read-out
module spi_ram #(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_SIZE   = 8,
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FRAME_WIDTH+1:0] rx_data,
  input  logic                   rx_valid,
  output logic [FRAME_WIDTH-1:0] dout,
  output logic                   tx_valid
);
  logic [FRAME_WIDTH-1:0] mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic [1:0]             cmd;
  logic [FRAME_WIDTH-1:0] data_byte;

  assign cmd       = rx_data[FRAME_WIDTH+1:FRAME_WIDTH];
  assign data_byte = rx_data[FRAME_WIDTH-1:0];

  // Address registers and read-data register; tx_valid pulses once per read-data command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          2'b00: wr_addr <= data_byte[ADDR_SIZE-1:0];
          2'b10: rd_addr <= data_byte[ADDR_SIZE-1:0];
          2'b11: begin
            dout     <= mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage write port; kept out of the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == 2'b01) mem[wr_addr] <= data_byte;
  end
endmodule

// Top level: slave -> rx bus -> RAM -> tx bus -> slave
module spi_ram_wrapper #(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_SIZE   = 8,
  parameter int FRAME_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);
  logic [FRAME_WIDTH+1:0] rx_data;
  logic                   rx_valid;
  logic [FRAME_WIDTH-1:0] tx_data;
  logic                   tx_valid;

  spi_slave #(
    .FRAME_WIDTH(FRAME_WIDTH)
  ) slave_inst (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  spi_ram #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .FRAME_WIDTH(FRAME_WIDTH)
  ) ram_inst (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .dout    (tx_data),
    .tx_valid(tx_valid)
  );
endmodule

// File: tb/tb_spi_ram_wrapper.sv
// tb/tb_spi_ram_wrapper.sv - directed and random frame bench with a read-data scoreboard
module tb_spi_ram_wrapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] model_mem [0:255];
  logic [7:0] exp_q [$];

  spi_ram_wrapper #(
    .MEM_DEPTH  (256),
    .ADDR_SIZE  (8),
    .FRAME_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // SS_n low, one setup edge, then frame bits 10..0 on successive edges; returns at the last-bit edge
  task automatic drive_frame(input logic [10:0] f);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(posedge clk);
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      MOSI = f[i];
      @(posedge clk);
    end
  endtask

  task automatic release_ss();
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_cmd(input logic [7:0] addr, input logic [7:0] data);
    drive_frame({3'b000, addr});
    release_ss();
    drive_frame({3'b001, data});
    release_ss();
    model_mem[addr] = data;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr);
    logic [7:0] expb;
    exp_q.push_back(model_mem[addr]);
    drive_frame({3'b110, addr});
    release_ss();
    drive_frame({3'b111, 8'($urandom)});
    @(negedge clk);
    check($sformatf("%s_idle_e0", tag), 32'(MISO), 32'h0);
    @(negedge clk);
    check($sformatf("%s_idle_e1", tag), 32'(MISO), 32'h0);
    expb = exp_q.pop_front();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("%s_bit%0d", tag, 7 - j), 32'(MISO), 32'(expb[7-j]));
    end
    @(negedge clk);
    check($sformatf("%s_after", tag), 32'(MISO), 32'h0);
    release_ss();
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rd;

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i) ^ 8'h5A;
      dut.ram_inst.mem[i] <= 8'(i) ^ 8'h5A;
    end
    model_mem[8'h3C] = 8'hA5;
    dut.ram_inst.mem[8'h3C] <= 8'hA5;

    repeat (3) @(negedge clk);
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_state", 32'(dut.slave_inst.state), 32'h0);
    check("rst_mem3c", 32'(dut.ram_inst.mem[8'h3C]), 32'hA5);
    check("rst_wr_addr", 32'(dut.ram_inst.wr_addr), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    drive_frame({3'b000, 8'h24});
    release_ss();
    drive_frame({3'b001, 8'h81});
    @(negedge clk);
    check("wr24_before", 32'(dut.ram_inst.mem[8'h24]), 32'h7E);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    check("wr24_after", 32'(dut.ram_inst.mem[8'h24]), 32'h81);
    repeat (2) @(negedge clk);
    model_mem[8'h24] = 8'h81;

    read_check("rd24", 8'h24);
    read_check("rd3c", 8'h3C);

    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(posedge clk);
    begin
      logic [4:0] part;
      part = 5'b00101;
      for (int i = 4; i >= 0; i--) begin
        @(negedge clk);
        MOSI = part[i];
        @(posedge clk);
      end
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_state", 32'(dut.slave_inst.state), 32'h0);
    check("abort_mem24", 32'(dut.ram_inst.mem[8'h24]), 32'h81);
    check("abort_wr_addr", 32'(dut.ram_inst.wr_addr), 32'h24);

    drive_frame({3'b001, 8'h55});
    release_ss();
    model_mem[8'h24] = 8'h55;
    check("post_abort_mem24", 32'(dut.ram_inst.mem[8'h24]), 32'h55);
    read_check("rd24b", 8'h24);

    for (int k = 0; k < 10; k++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom);
      write_cmd(ra, rd);
      read_check($sformatf("rand%0d", k), ra);
    end

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
